// File: rtl/mem_a_loader.sv
// mem_a_loader: write-side controller for the matrix-A skew memory.
// Accepts one packed A row per valid/ready beat and writes it into the skew
// memory row port. After the last row it holds the memory enable for the
// drain window, so the skewed rows reach the systolic array, and then it
// pulses done.
module mem_a_loader #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [DIM*BITS_AB-1:0]       in_data,
    output logic                         in_ready,
    output logic signed [BITS_AB-1:0]    Ain [DIM],
    output logic [$clog2(DIM)-1:0]       Arow,
    output logic                         WrEn,
    output logic                         en,
    output logic                         busy,
    output logic                         done
);

    localparam int RW = $clog2(DIM);
    localparam int SW = $clog2(2*DIM);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;

    state_t                    state_q, state_d;
    logic [RW-1:0]             rowCnt_q, rowCnt_d;
    logic [SW-1:0]             strCnt_q, strCnt_d;
    logic signed [BITS_AB-1:0] ain_q [DIM];
    logic signed [BITS_AB-1:0] ain_d [DIM];
    logic [RW-1:0]             arow_q, arow_d;
    logic                      wrEn_q, wrEn_d;
    logic                      en_q, en_d;
    logic                      done_q, done_d;

    // State register plus every registered output; synchronous active-low reset clears all of it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rowCnt_q <= '0;
            strCnt_q <= '0;
            arow_q   <= '0;
            wrEn_q   <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            for (int j = 0; j < DIM; j++) begin
                ain_q[j] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rowCnt_q <= rowCnt_d;
            strCnt_q <= strCnt_d;
            arow_q   <= arow_d;
            wrEn_q   <= wrEn_d;
            en_q     <= en_d;
            done_q   <= done_d;
            for (int j = 0; j < DIM; j++) begin
                ain_q[j] <= ain_d[j];
            end
        end
    end

    // Next state and next register values; the first STREAM cycle still carries the last row write, so drain counting starts after it
    always_comb begin
        state_d  = state_q;
        rowCnt_d = rowCnt_q;
        strCnt_d = strCnt_q;
        ain_d    = ain_q;
        arow_d   = arow_q;
        wrEn_d   = 1'b0;
        en_d     = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    state_d  = LOAD;
                    rowCnt_d = '0;
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    for (int j = 0; j < DIM; j++) begin
                        ain_d[j] = in_data[j*BITS_AB +: BITS_AB];
                    end
                    arow_d = rowCnt_q;
                    wrEn_d = 1'b1;
                    en_d   = 1'b1;
                    if (rowCnt_q == RW'(DIM-1)) begin
                        state_d  = STREAM;
                        rowCnt_d = '0;
                        strCnt_d = '0;
                    end else begin
                        rowCnt_d = rowCnt_q + RW'(1);
                    end
                end
            end
            STREAM: begin
                if (wrEn_q) begin
                    en_d = 1'b1;
                end else if (strCnt_q == SW'(2*DIM-2)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    strCnt_d = strCnt_q + SW'(1);
                    en_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: in_ready and busy come from the state register, the rest are register copies
    always_comb begin
        in_ready = (state_q == LOAD);
        busy     = (state_q != IDLE);
        WrEn     = wrEn_q;
        en       = en_q;
        done     = done_q;
        Arow     = arow_q;
        for (int j = 0; j < DIM; j++) begin
            Ain[j] = ain_q[j];
        end
    end

endmodule

// File: tb/tb_mem_a_loader.sv
// tb_mem_a_loader: randomized bench for mem_a_loader.
// The reference model tracks the load as time windows. There is a load window
// in which in_ready is expected, a write one cycle after each accepted beat, a
// drain window of 15 cycles after the last write, and done in the cycle after
// the drain.
module tb_mem_a_loader;

    logic              clk;
    logic              rstN;
    logic              start;
    logic              inValid;
    logic [63:0]       inData;
    logic              inReady;
    logic signed [7:0] ain [8];
    logic [2:0]        arow;
    logic              wrEn;
    logic              en;
    logic              busy;
    logic              done;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state, indexed by cycle number
    int                cyc       = 0;
    bit                loadOpen  = 0;
    int                rowsTaken = 0;
    int                lastWrCyc = -1;
    int                drainEnd  = -1;
    int                doneCyc   = -1;
    bit                expWr     = 0;
    bit                expEn     = 0;
    logic [2:0]        expArow   = '0;
    logic signed [7:0] expAin [8];

    mem_a_loader #(.BITS_AB(8), .DIM(8)) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .start    (start),
        .in_valid (inValid),
        .in_data  (inData),
        .in_ready (inReady),
        .Ain      (ain),
        .Arow     (arow),
        .WrEn     (wrEn),
        .en       (en),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock with a 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, observed, expected);
        end
    endtask

    function automatic logic [63:0] makeRow(input int patMode, input int row);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) begin
            if (patMode == 1) begin
                r[j*8 +: 8] = 8'(row + j + 1);
            end else if (patMode == 2 && row == 2) begin
                r[j*8 +: 8] = 8'h80;
            end else begin
                r[j*8 +: 8] = 8'($urandom);
            end
        end
        return r;
    endfunction

    task automatic applyStimulus(input bit rstIn, input bit startIn, input bit validIn,
                                 input logic [63:0] dataIn);
        bit busyPrev;
        bit hs;
        rstN    = rstIn;
        start   = startIn;
        inValid = validIn;
        inData  = dataIn;
        @(posedge clk);
        cyc++;
        if (!rstIn) begin
            loadOpen  = 0;
            rowsTaken = 0;
            lastWrCyc = -1;
            drainEnd  = -1;
            doneCyc   = -1;
            expWr     = 0;
            expEn     = 0;
            expArow   = '0;
            for (int j = 0; j < 8; j++) expAin[j] = '0;
        end else begin
            busyPrev = loadOpen || (cyc - 1 <= drainEnd);
            hs       = loadOpen && validIn;
            expWr    = hs;
            if (hs) begin
                for (int j = 0; j < 8; j++) expAin[j] = dataIn[j*8 +: 8];
                expArow = 3'(rowsTaken);
                rowsTaken++;
                if (rowsTaken == 8) begin
                    loadOpen  = 0;
                    lastWrCyc = cyc;
                    drainEnd  = cyc + 15;
                    doneCyc   = cyc + 16;
                end
            end else if (startIn && !busyPrev && doneCyc != cyc - 1) begin
                loadOpen  = 1;
                rowsTaken = 0;
            end
            expEn = hs || (cyc > lastWrCyc && cyc <= drainEnd);
        end
        #1;
        checkOutput("in_ready", inReady, loadOpen);
        checkOutput("WrEn", wrEn, expWr);
        checkOutput("en", en, expEn);
        checkOutput("busy", busy, loadOpen || (cyc <= drainEnd));
        checkOutput("done", done, cyc == doneCyc);
        checkOutput("Arow", arow, expArow);
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("Ain%0d", j), ain[j], expAin[j]);
        end
    endtask

    // validMode: 0 always valid, 1 pattern 1,0,0, 2 random; pulse/reset offsets are cycles after start (0 = none)
    task automatic runLoad(input int validMode, input int patMode, input int startA,
                           input int startB, input int resetAt);
        bit v;
        applyStimulus(1, 1, 0, makeRow(0, 0));
        for (int k = 1; k <= 150; k++) begin
            case (validMode)
                0:       v = 1;
                1:       v = ((k % 3) == 1);
                default: v = (patMode == 2 && rowsTaken == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            applyStimulus(k != resetAt, (k == startA) || (k == startB), v, makeRow(patMode, rowsTaken));
            if (!loadOpen && cyc > drainEnd && cyc > doneCyc) break;
        end
        checkOutput("idleAfterLoad", busy, 0);
    endtask

    // Directed scenarios from the test plan followed by a random soak
    initial begin
        rstN    = 1'b0;
        start   = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        for (int j = 0; j < 8; j++) expAin[j] = '0;

        repeat (2) applyStimulus(0, 1, 1, makeRow(0, 0));
        runLoad(0, 1, 0, 0, 0);
        runLoad(1, 0, 0, 0, 0);
        runLoad(2, 2, 0, 0, 0);
        runLoad(0, 0, 4, 14, 0);
        runLoad(0, 0, 25, 0, 0);
        runLoad(0, 0, 0, 0, 16);
        runLoad(0, 1, 0, 0, 0);

        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 149) != 0, $urandom_range(0, 5) == 0,
                          1'($urandom_range(0, 1)), makeRow(0, rowsTaken));
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
